// File: rtl/pc_fetch_if.sv
// Control-unit / fetch-stage signal bundle for pc_fetch_unit.
// The master side is the control unit and ALU, which produce the control inputs and consume pc.
interface pc_fetch_if #(
    parameter int PC_WIDTH  = 10,
    parameter int CNT_WIDTH = 16
);
    logic                 Jump;
    logic                 JR;
    logic                 JAL;
    logic                 Branch;
    logic                 BranchTaken;
    logic                 HLT;
    logic                 InReq;
    logic                 InAck;
    logic [15:0]          imm;
    logic [25:0]          target;
    logic [31:0]          rs_data;
    logic [PC_WIDTH-1:0]  pc;
    logic [PC_WIDTH-1:0]  link_addr;
    logic                 link_we;
    logic                 stall;
    logic                 halted;
    logic [CNT_WIDTH-1:0] instr_count;

    modport master (
        output Jump, JR, JAL, Branch, BranchTaken, HLT, InReq, InAck, imm, target, rs_data,
        input  pc, link_addr, link_we, stall, halted, instr_count
    );

    modport slave (
        input  Jump, JR, JAL, Branch, BranchTaken, HLT, InReq, InAck, imm, target, rs_data,
        output pc, link_addr, link_we, stall, halted, instr_count
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencing: next-PC selection, run/wait/halt state,
// JAL link address, and a saturating retired-instruction counter.
module pc_fetch_unit #(
    parameter int PC_WIDTH  = 10,
    parameter int RESET_PC  = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    pc_fetch_if.slave    bus
);
    // state    | meaning
    // ST_RUN   | executing one instruction per edge
    // ST_WAIT  | IN instruction waiting for InAck; pc held
    // ST_HALT  | frozen until reset
    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT} state_t;

    state_t               state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d, pc_inc;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]          br_sum;
    logic                 retire;
    logic                 unused_bits;

    assign pc_inc = pc_q + PC_WIDTH'(1);
    assign br_sum = {{(32-PC_WIDTH){1'b0}}, pc_q} + 32'd1 + {{16{bus.imm[15]}}, bus.imm};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        retire  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.HLT) begin
                    state_d = ST_HALT;
                end else if (bus.InReq && !bus.InAck) begin
                    state_d = ST_WAIT;
                end else begin
                    retire = 1'b1;
                    if (bus.Jump && bus.JR)
                        pc_d = bus.rs_data[PC_WIDTH-1:0];
                    else if (bus.Jump)
                        pc_d = bus.target[PC_WIDTH-1:0];
                    else if (bus.Branch && bus.BranchTaken)
                        pc_d = br_sum[PC_WIDTH-1:0];
                    else
                        pc_d = pc_inc;
                end
            end
            ST_WAIT: begin
                if (bus.InAck) begin
                    state_d = ST_RUN;
                    pc_d    = pc_inc;
                    retire  = 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Counter saturates rather than wrapping so long runs stay monotonic.
        if (retire && (cnt_q != {CNT_WIDTH{1'b1}}))
            cnt_d = cnt_q + CNT_WIDTH'(1);
        else
            cnt_d = cnt_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            pc_q    <= PC_WIDTH'(RESET_PC);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.link_addr   = pc_inc;
    assign bus.link_we     = bus.JAL & bus.Jump & (state_q == ST_RUN) & ~bus.HLT;
    assign bus.stall       = (state_q == ST_WAIT);
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.instr_count = cnt_q;

    assign unused_bits = ^{bus.rs_data[31:PC_WIDTH], bus.target[25:PC_WIDTH], br_sum[31:PC_WIDTH]};
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: expectations are queued per cycle and checked by a
// negedge monitor; a second 4-bit-counter instance checks count saturation.
module tb_pc_fetch_unit;
    logic clock;
    logic reset_n;
    logic rst2_n;

    pc_fetch_if #(.PC_WIDTH(10), .CNT_WIDTH(16)) bus ();
    pc_fetch_if #(.PC_WIDTH(10), .CNT_WIDTH(4))  bus2 ();

    pc_fetch_unit #(.PC_WIDTH(10), .RESET_PC(0), .CNT_WIDTH(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    pc_fetch_unit #(.PC_WIDTH(10), .RESET_PC(0), .CNT_WIDTH(4)) dut_sat (
        .clock   (clock),
        .reset_n (rst2_n),
        .bus     (bus2.slave)
    );

    typedef struct {
        string name;
        int    pc;
        int    cnt;
        logic  stall;
        logic  halted;
        logic  lwe;
        int    la;
    } exp_t;

    typedef struct {
        int pc;
        int cnt;
    } exp2_t;

    exp_t  q[$];
    exp2_t q2[$];
    int    passed = 0;
    int    total  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        exp_t  e;
        exp2_t e2;
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (bus.pc !== 10'(e.pc) || bus.instr_count !== 16'(e.cnt) ||
                bus.stall !== e.stall || bus.halted !== e.halted ||
                bus.link_we !== e.lwe || bus.link_addr !== 10'(e.la)) begin
                $display("FAIL %s: got pc=%0d cnt=%0d stall=%b halted=%b link_we=%b link_addr=%0d, want pc=%0d cnt=%0d stall=%b halted=%b link_we=%b link_addr=%0d",
                         e.name, bus.pc, bus.instr_count, bus.stall, bus.halted, bus.link_we, bus.link_addr,
                         e.pc, e.cnt, e.stall, e.halted, e.lwe, e.la);
            end else begin
                passed++;
            end
        end
        if (q2.size() > 0) begin
            e2 = q2.pop_front();
            total++;
            if (bus2.pc !== 10'(e2.pc) || bus2.instr_count !== 4'(e2.cnt)) begin
                $display("FAIL sat_count: got pc=%0d cnt=%0d, want pc=%0d cnt=%0d",
                         bus2.pc, bus2.instr_count, e2.pc, e2.cnt);
            end else begin
                passed++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ctl(input logic j, jr, jal, br, bt, hlt, irq, iack,
                       input logic [15:0] im, input logic [25:0] tg, input logic [31:0] rs);
        bus.Jump        = j;
        bus.JR          = jr;
        bus.JAL         = jal;
        bus.Branch      = br;
        bus.BranchTaken = bt;
        bus.HLT         = hlt;
        bus.InReq       = irq;
        bus.InAck       = iack;
        bus.imm         = im;
        bus.target      = tg;
        bus.rs_data     = rs;
    endtask

    task automatic idle();
        ctl(0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    endtask

    task automatic expect_st(input string nm, input int p, input int c,
                             input logic st, input logic hl, input logic lwe, input int la);
        exp_t e;
        e.name = nm; e.pc = p; e.cnt = c; e.stall = st; e.halted = hl; e.lwe = lwe; e.la = la;
        q.push_back(e);
    endtask

    initial begin
        bus2.Jump = 0; bus2.JR = 0; bus2.JAL = 0; bus2.Branch = 0; bus2.BranchTaken = 0;
        bus2.HLT = 0; bus2.InReq = 0; bus2.InAck = 0;
        bus2.imm = '0; bus2.target = '0; bus2.rs_data = '0;
        rst2_n = 1'b0;
        tick();
        q2.push_back('{pc: 0, cnt: 0});
        rst2_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            q2.push_back('{pc: i, cnt: (i > 15) ? 15 : i});
        end
    end

    initial begin
        reset_n = 1'b0;
        idle();
        tick();
        expect_st("reset", 0, 0, 0, 0, 0, 1);
        reset_n = 1'b1;

        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 10) ctl(0, 0, 0, 1, 1, 0, 0, 0, 16'hFFFD, 26'h0, 32'h0);
            expect_st("sequential", i, i, 0, 0, 0, i + 1);
        end
        tick(); idle();
        expect_st("br_taken_neg", 8, 11, 0, 0, 0, 9);
        tick();
        expect_st("seq_after_br", 9, 12, 0, 0, 0, 10);
        tick(); ctl(0, 0, 0, 1, 0, 0, 0, 0, 16'hFFFD, 26'h0, 32'h0);
        expect_st("br_setup", 10, 13, 0, 0, 0, 11);
        tick(); ctl(1, 0, 0, 0, 0, 0, 0, 0, 16'h0, 26'h3FF, 32'h0);
        expect_st("br_not_taken", 11, 14, 0, 0, 0, 12);
        tick(); ctl(0, 0, 0, 1, 1, 0, 0, 0, 16'h0005, 26'h0, 32'h0);
        expect_st("jump_to_max", 1023, 15, 0, 0, 0, 0);
        tick(); ctl(0, 0, 0, 1, 1, 0, 0, 0, 16'hFFFE, 26'h0, 32'h0);
        expect_st("br_wrap_fwd", 5, 16, 0, 0, 0, 6);
        tick(); ctl(1, 0, 0, 1, 1, 0, 0, 0, 16'h0010, 26'h3FFFE00, 32'h0);
        expect_st("br_back", 4, 17, 0, 0, 0, 5);
        tick(); ctl(1, 0, 0, 0, 0, 0, 0, 0, 16'h0, 26'h7, 32'h0);
        expect_st("jump_trunc_over_br", 512, 18, 0, 0, 0, 513);
        tick(); ctl(1, 0, 1, 0, 0, 0, 0, 0, 16'h0, 26'h155, 32'h0);
        expect_st("jal_link", 7, 19, 0, 0, 1, 8);
        tick(); ctl(1, 1, 0, 0, 0, 0, 0, 0, 16'h0, 26'h2AA, 32'h12345);
        expect_st("jal_target", 341, 20, 0, 0, 0, 342);
        tick(); ctl(0, 1, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0FF);
        expect_st("jr", 837, 21, 0, 0, 0, 838);
        tick(); ctl(1, 0, 0, 0, 0, 0, 0, 0, 16'h0, 26'd20, 32'h0);
        expect_st("jr_without_jump", 838, 22, 0, 0, 0, 839);

        tick(); ctl(0, 0, 0, 0, 0, 0, 1, 0, 16'h0, 26'h0, 32'h0);
        expect_st("in_setup", 20, 23, 0, 0, 0, 21);
        tick(); ctl(1, 0, 1, 1, 1, 0, 1, 0, 16'h0, 26'd99, 32'h0);
        expect_st("wait1", 20, 23, 1, 0, 0, 21);
        tick();
        expect_st("wait2", 20, 23, 1, 0, 0, 21);
        tick(); ctl(0, 0, 0, 0, 0, 0, 0, 1, 16'h0, 26'h0, 32'h0);
        expect_st("wait3", 20, 23, 1, 0, 0, 21);
        tick(); ctl(0, 0, 0, 0, 0, 0, 1, 1, 16'h0, 26'h0, 32'h0);
        expect_st("in_release", 21, 24, 0, 0, 0, 22);
        tick(); ctl(0, 0, 0, 0, 0, 0, 1, 0, 16'h0, 26'h0, 32'h0);
        expect_st("in_with_ack", 22, 25, 0, 0, 0, 23);
        tick(); ctl(0, 0, 0, 0, 0, 0, 0, 1, 16'h0, 26'h0, 32'h0);
        expect_st("wait_again", 22, 25, 1, 0, 0, 23);
        tick(); ctl(0, 0, 0, 0, 0, 0, 1, 1, 16'h0, 26'h0, 32'h0);
        expect_st("release_held_ack", 23, 26, 0, 0, 0, 24);
        tick(); ctl(1, 0, 0, 0, 0, 0, 0, 0, 16'h0, 26'd30, 32'h0);
        expect_st("in_no_wait", 24, 27, 0, 0, 0, 25);

        tick(); ctl(1, 0, 1, 0, 0, 1, 0, 0, 16'h0, 26'd99, 32'h0);
        expect_st("halt_beats_jal", 30, 28, 0, 0, 0, 31);
        tick(); ctl(1, 0, 1, 1, 1, 0, 1, 1, 16'h0005, 26'd5, 32'h0);
        expect_st("halted", 30, 28, 0, 1, 0, 31);
        tick();
        expect_st("halt_frozen", 30, 28, 0, 1, 0, 31);
        tick(); idle();
        #2 reset_n = 1'b0;
        expect_st("async_reset", 0, 0, 0, 0, 0, 1);
        @(negedge clock);
        #1 reset_n = 1'b1;
        tick();
        expect_st("post_reset_run", 1, 1, 0, 0, 0, 2);

        tick();
        tick();
        if (q.size() != 0 || q2.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d/%0d pending expectations, want 0/0", q.size(), q2.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and fetch-sequencing stage of the single-cycle processor. It holds the instruction address, drives it to instruction memory, and computes the next address from the control unit's Jump/JR/JAL/Branch/HLT outputs and the ALU branch-compare result. It also owns the run/halt/input-wait state and produces the JAL link address. It sits directly upstream of instruction decode: its `pc` output addresses the instruction whose opcode feeds the control unit in the same cycle.

## Interface
- `PC_WIDTH`, default 10: instruction address width in words.
- `RESET_PC`, default 0: PC value loaded on reset.
- `CNT_WIDTH`, default 16: width of the retired-instruction counter.

Ports:
- `clock` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `Jump` input 1: from the control unit; asserted for J, JR and JAL.
- `JR` input 1: from the control unit; register-indirect jump (asserted together with `Jump`).
- `JAL` input 1: from the control unit; jump-and-link.
- `Branch` input 1: from the control unit; conditional branch instruction.
- `BranchTaken` input 1: ALU compare result (1 = condition true).
- `HLT` input 1: halt instruction.
- `InReq` input 1: IN instruction; wait for external data.
- `InAck` input 1: external input valid (switch/enter strobe).
- `imm` input 16: branch offset in words, two's complement.
- `target` input 26: absolute jump target field.
- `rs_data` input 32: register-file RS value, used for JR.
- `pc` output PC_WIDTH: current instruction address (registered).
- `link_addr` output PC_WIDTH: `pc`+1, mod 2^PC_WIDTH (combinational).
- `link_we` output 1: write strobe for the link register (combinational).
- `stall` output 1: 1 while in WAIT_IN (registered state decode).
- `halted` output 1: 1 while in HALT (registered state decode).
- `instr_count` output CNT_WIDTH: retired-instruction count.

## Operation
- States: RUN, WAIT_IN, HALT. Reset puts the unit in RUN with `pc`=RESET_PC and `instr_count`=0. At reset, `stall`=0 and `halted`=0; `link_we` and `link_addr` follow their combinational definitions.
- Next-PC priority in RUN, highest first:
  - `HLT`: `pc` holds and the state goes to HALT.
  - `InReq` with `InAck`=0: `pc` holds and the state goes to WAIT_IN.
  - `Jump`&`JR`: next PC = `rs_data[PC_WIDTH-1:0]`.
  - `Jump` (J/JAL): next PC = `target[PC_WIDTH-1:0]`.
  - `Branch`&`BranchTaken`: next PC = `pc`+1+sext(`imm`), truncated to PC_WIDTH.
  - Otherwise, including `InReq` with `InAck`=1 and `Branch` not taken: next PC = `pc`+1.
- All PC arithmetic is modulo 2^PC_WIDTH. Incrementing from all-ones wraps to 0, and a negative offset below 0 wraps.
- `link_we` = `JAL` & `Jump` & (state==RUN) & ~`HLT`.
- WAIT_IN:
  - `pc` holds and `stall`=1.
  - In any cycle with `InAck`=1: `pc`←`pc`+1 and the state returns to RUN.
  - Control inputs other than `InAck` are ignored.
- HALT: `pc` and `instr_count` freeze, and `halted`=1. Only `reset_n` exits HALT; every other input is ignored.
- `instr_count` increments on each edge where an instruction retires:
  - RUN with no hold (i.e. not `HLT`, not an `InReq` wait).
  - WAIT_IN with `InAck`=1.
  - The count saturates at all-ones.
- Contradictory inputs resolve by the priority order above. Examples: `Branch`+`Jump` means jump; `HLT`+anything means halt; `JR` without `Jump` is treated as no jump.

## Timing
- Single-cycle: the control inputs for the instruction at `pc` are valid in the same cycle, and `pc` updates on the next rising edge. Branch/jump latency is 1 edge.
- `reset_n` low forces `pc`, state and `instr_count` immediately, without waiting for `clock`. This applies mid-operation too, including from WAIT_IN or HALT.
- After `reset_n` deasserts, the first rising edge is a normal RUN evaluation.
- `InAck` is sampled only on rising edges. A 1-cycle pulse is sufficient; holding it high for multiple cycles releases WAIT_IN once only, and the next IN instruction in RUN then completes without waiting.
- `stall` and `halted` change only on clock edges or reset.

## Test plan
- Reset and sequential: `reset_n` low then high, no control asserted, 5 edges → `pc` = 0,1,2,3,4,5; `instr_count`=5; `stall`=`halted`=0.
- Branches: at `pc`=10, `Branch`=1, `imm`=-3, `BranchTaken`=1 → `pc`=8. Same with `BranchTaken`=0 → `pc`=11. `imm`=+5 at `pc`=1023 → `pc`=5 (wrap).
- Jumps: at `pc`=4, `Jump`=1, `target`=0x200 → `pc`=0x200. `Jump`=`JAL`=1 at `pc`=7 → `link_we`=1 and `link_addr`=8 during that cycle, then `pc`=`target`. `Jump`=`JR`=1, `rs_data`=0x12345 → `pc`=0x345.
- Input wait: `InReq`=1 at `pc`=20, `InAck`=0 for 3 edges → `pc`=20 and `stall`=1, count unchanged. `InAck` pulse → `pc`=21, `stall`=0, count +1. `InReq`+`InAck` together → `pc` advances in one edge.
- Halt and priority: `HLT`+`Jump` at `pc`=30 → `pc`=30 and `halted`=1. Further `Jump`/`Branch`/`InAck` activity leaves `pc` and count frozen. `reset_n` pulse asynchronous to `clock` → `pc`=0 and `halted`=0 before the next edge.
- Counter saturation: with `CNT_WIDTH`=4, run 20 sequential edges → `instr_count` stops at 15.
